ex2_onehot_hold_dec: RTL
========================

// Module: ex2_onehot_hold_dec
// PURPOSE
//   Decoder side of the 8-to-3 priority encoder path: accepts a 3-bit index plus
//   "any-input" flag and drives an 8-bit one-hot LED bank. Each decoded LED is
//   pulse-stretched for HOLD_CYCLES clocks so short encoder events are visible on
//   the board. Keeps the last decoded index and a saturating event count for the
//   7-seg display.
// PARAMETERS
//   CODE_W       3   index width; output width is 2**CODE_W (8)
//   HOLD_CYCLES  4   cycles each LED stays lit after a hit; legal range 1..255
//   CNT_W        8   width of hit_cnt (saturating)
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   rst        in   1       asynchronous reset, active-high
//   en         in   1       block enable (SW); low = ready deasserted, LEDs cleared
//   in_valid   in   1       in_code/in_sig qualify this cycle
//   in_ready   out  1       block can accept; in_ready = en (combinational)
//   in_code    in   CODE_W  encoded index to light
//   in_sig     in   1       1 = real event; 0 = "no input", accepted but ignored
//   onehot     out  8       stretched one-hot LED outputs (several may be lit)
//   active     out  1       OR of onehot
//   last_code  out  CODE_W  index of most recent accepted in_sig=1 transfer
//   hit_cnt    out  CNT_W   count of accepted in_sig=1 transfers, saturates
// BEHAVIOUR
//   - Reset (async, rst=1): all 8 hold counters=0, onehot=0, active=0,
//     last_code=0, hit_cnt=0. Leaving reset: first edge behaves normally.
//   - Transfer: accept = in_valid & in_ready. No backpressure besides en.
//   - Per-bit hold counter cnt[i] (width clog2(HOLD_CYCLES+1)), priority order:
//     1) en=0                          -> cnt[i] <= 0
//     2) accept & in_sig & in_code==i  -> cnt[i] <= HOLD_CYCLES (reload)
//     3) cnt[i]!=0                     -> cnt[i] <= cnt[i]-1
//     4) else hold 0
//   - onehot[i] = (cnt[i]!=0), decoded from registers (no comb path from inputs).
//   - Latency: transfer accepted on edge T -> onehot[code] high for cycles
//     T+1..T+HOLD_CYCLES exactly, low at T+HOLD_CYCLES+1 unless retriggered.
//   - Retrigger on a lit bit (incl. cnt==1) reloads; no low gap between pulses.
//   - Different codes on consecutive transfers: earlier bit continues its own
//     countdown; multiple bits lit concurrently is legal.
//   - in_sig=0 transfer: consumed, no counter, last_code or hit_cnt change.
//   - last_code <= in_code on accept & in_sig; otherwise holds (also holds when en=0).
//   - hit_cnt <= hit_cnt+1 on accept & in_sig, stops at 2**CNT_W-1, never wraps;
//     holds when en=0; cleared only by rst.
//   - en falls: in_ready=0 same cycle; onehot=0 from next edge. Input while
//     en=0 is ignored even with in_valid=1.
//   - rst mid-pulse: onehot drops immediately (async), counters restart at 0.
//   - in_code with X/out-of-range impossible (full decode of CODE_W bits).
// TESTING
//   1 Single hit: en=1, one transfer code=5 sig=1 at T -> onehot=8'b0010_0000
//     T+1..T+4, 0 at T+5; last_code=5; hit_cnt=1; active matches.
//   2 Retrigger: code=2 at T and T+3 -> bit2 high T+1..T+7 continuously, hit_cnt=2.
//   3 Overlap: code=0 at T, code=7 at T+2 -> onehot=8'h01 at T+1..T+2,
//     8'h81 at T+3..T+4, 8'h80 at T+5..T+6, 0 at T+7.
//   4 No-input: in_valid=1 sig=0 code=3 -> in_ready=1, onehot stays 0,
//     last_code and hit_cnt unchanged.
//   5 Enable drop: code=4 lit, en=0 at T+2 -> in_ready=0 at T+2, onehot=0 at T+3;
//     valid transfers during en=0 leave hit_cnt unchanged; en=1 resumes normally.
//   6 Saturation & reset: 300 sig=1 transfers -> hit_cnt=255; async rst pulse
//     mid-hold -> onehot=0, last_code=0, hit_cnt=0 before next clock edge.

Source files
------------

// File: rtl/ex2_onehot_hold_dec.sv
// -----------------------------------------------------------------------------
// ex2_onehot_hold_dec
//   Decoder side of the 8-to-3 priority encoder path. Each accepted real event
//   (in_sig=1) lights the LED selected by in_code for HOLD_CYCLES clocks. This
//   pulse stretch makes short encoder events visible on the board. The block
//   also keeps the most recent decoded index and a saturating hit counter for
//   the 7-segment display.
//
// Ports
//   clk        in   system clock, all state on rising edge
//   rst        in   asynchronous reset, active-high
//   en         in   block enable; low deasserts in_ready and clears the LEDs
//   in_valid   in   in_code/in_sig qualify this cycle
//   in_ready   out  block can accept (equals en)
//   in_code    in   encoded index to light
//   in_sig     in   1 = real event, 0 = "no input" (accepted, ignored)
//   onehot     out  stretched one-hot LED outputs (several may be lit)
//   active     out  OR of onehot
//   last_code  out  index of the most recent accepted in_sig=1 transfer
//   hit_cnt    out  saturating count of accepted in_sig=1 transfers
// -----------------------------------------------------------------------------
module ex2_onehot_hold_dec #(
  parameter int CODE_W      = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CODE_W-1:0]      in_code,
  input  logic                   in_sig,
  output logic [(1<<CODE_W)-1:0] onehot,
  output logic                   active,
  output logic [CODE_W-1:0]      last_code,
  output logic [CNT_W-1:0]       hit_cnt
);

  localparam int N  = 1 << CODE_W;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]    CNT_ZERO  = {HW{1'b0}};
  localparam logic [HW-1:0]    CNT_ONE   = HW'(1);
  localparam logic [CNT_W-1:0] HIT_MAX   = {CNT_W{1'b1}};

  logic [HW-1:0] cnt [N];
  logic          accept;
  logic          hit;

  // Handshake: the only backpressure is the enable switch.
  always_comb begin
    in_ready = en;
    accept   = in_valid & en;
    hit      = in_valid & en & in_sig;
  end

  // Per-LED hold counters: enable-clear, then reload on hit, then count down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cnt[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!en) begin
          cnt[i] <= CNT_ZERO;
        end else if (hit && (in_code == CODE_W'(i))) begin
          // Reload also covers a retrigger on a lit bit, so no low gap appears.
          cnt[i] <= HOLD_LOAD;
        end else if (cnt[i] != CNT_ZERO) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end else begin
          cnt[i] <= CNT_ZERO;
        end
      end
    end
  end

  // LED decode from counter state only; no path from the inputs.
  always_comb begin
    onehot = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      onehot[i] = (cnt[i] != CNT_ZERO);
    end
    active = |onehot;
  end

  // Display state: last real index and a hit counter that sticks at its maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_code <= {CODE_W{1'b0}};
      hit_cnt   <= {CNT_W{1'b0}};
    end else if (hit) begin
      last_code <= in_code;
      if (hit_cnt != HIT_MAX) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end else begin
        hit_cnt <= hit_cnt;
      end
    end else begin
      last_code <= last_code;
      hit_cnt   <= hit_cnt;
    end
  end

  // accept is kept as a named term for readability of the handshake; in_sig=0
  // transfers are consumed with no state change, so only hit drives state.
  logic unused_ok;
  always_comb begin
    unused_ok = accept;
  end

endmodule
